// File: rtl/mem_axil_bridge.sv
// mem_axil_bridge: single-outstanding memory request to AXI4-Lite master bridge.
// Every output is registered; one DONE cycle separates consecutive transactions.
module mem_axil_bridge #(
    parameter logic [2:0] AXI_PROT = 3'b000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_strb_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        mem_err_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] awaddr_o,
    output logic [2:0]  awprot_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    input  logic        bvalid_i,
    output logic        bready_o,
    input  logic [1:0]  bresp_i,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [31:0] araddr_o,
    output logic [2:0]  arprot_o,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i
);
    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, DONE} state_t;
    state_t      r_state;
    logic        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_done, r_err;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_strb;
    logic        w_aw_ok, w_w_ok, w_unused;
    // A channel counts as finished if it completed earlier or is completing now.
    assign w_aw_ok  = !r_awvalid || awready_i;
    assign w_w_ok   = !r_wvalid || wready_i;
    assign w_unused = ^{bresp_i[0], rresp_i[0]};
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_rdata   <= 32'h0;
            r_strb    <= 4'h0;
        end else begin
            case (r_state)
                IDLE: if (mem_req_i) begin
                    r_addr    <= mem_addr_i;
                    r_wdata   <= mem_wdata_i;
                    r_strb    <= mem_strb_i;
                    r_awvalid <= mem_we_i;
                    r_wvalid  <= mem_we_i;
                    r_arvalid <= !mem_we_i;
                    r_state   <= mem_we_i ? WR_AW_W : RD_AR;
                end
                WR_AW_W: begin
                    if (awready_i) r_awvalid <= 1'b0;
                    if (wready_i) r_wvalid <= 1'b0;
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_B;
                    end
                end
                WR_B: if (bvalid_i) begin
                    r_bready <= 1'b0;
                    r_err    <= bresp_i[1];
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                RD_AR: if (arready_i) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_state   <= RD_R;
                end
                RD_R: if (rvalid_i) begin
                    r_rready <= 1'b0;
                    r_rdata  <= rdata_i;
                    r_err    <= rresp_i[1];
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign mem_rdata_o = r_rdata;
    assign mem_done_o  = r_done;
    assign mem_err_o   = r_err;
    assign awvalid_o   = r_awvalid;
    assign awaddr_o    = r_addr;
    assign awprot_o    = AXI_PROT;
    assign wvalid_o    = r_wvalid;
    assign wdata_o     = r_wdata;
    assign wstrb_o     = r_strb;
    assign bready_o    = r_bready;
    assign arvalid_o   = r_arvalid;
    assign araddr_o    = r_addr;
    assign arprot_o    = AXI_PROT;
    assign rready_o    = r_rready;
endmodule

// File: tb/tb_mem_axil_bridge.sv
// tb_mem_axil_bridge: directed vector table plus hand sequences for held requests and mid-transaction reset.
module tb_mem_axil_bridge;
    localparam logic [2:0] PROT = 3'b101;
    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_req_i = 0, mem_we_i = 0;
    logic [31:0] mem_addr_i = 0, mem_wdata_i = 0;
    logic [3:0]  mem_strb_i = 0;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o, mem_err_o;
    logic        awvalid_o, awready_i = 0, wvalid_o, wready_i = 0, bvalid_i = 0, bready_o;
    logic [31:0] awaddr_o, wdata_o, araddr_o;
    logic [2:0]  awprot_o, arprot_o;
    logic [3:0]  wstrb_o;
    logic [1:0]  bresp_i = 0, rresp_i = 0;
    logic        arvalid_o, arready_i = 0, rvalid_i = 0, rready_o;
    logic [31:0] rdata_i = 0;

    mem_axil_bridge #(.AXI_PROT(PROT)) dut (
        .clk_i(clk), .rst_i(rst), .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_strb_i(mem_strb_i),
        .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .mem_err_o(mem_err_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o), .awprot_o(awprot_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o), .arprot_o(arprot_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i), .rresp_i(rresp_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata;
        logic [3:0]  strb;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  resp;
        logic [31:0] rdat;
        int          drop, done_exp;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vt[8];

    int tests = 0, fails = 0;
    int cyc, done_n, done_at[4];
    logic prev_done;
    int aw_d, w_d, b_d, ar_d, r_d;
    int aw_c, w_c, b_c, ar_c, r_c, aw_hi, w_hi, ar_hi;
    logic [1:0]  s_resp;
    logic [31:0] s_rdat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Slave responds with configurable wait states, driven at the negedge from the DUT's registered outputs.
    task automatic slave_step();
        if (mem_done_o) begin
            chk($sformatf("done_single_c%0d", cyc), {31'b0, prev_done}, 32'd0);
            if (done_n < 4) done_at[done_n] = cyc;
            done_n++;
            aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        end
        prev_done = mem_done_o;
        awready_i = awvalid_o && aw_c >= aw_d;
        wready_i  = wvalid_o && w_c >= w_d;
        bvalid_i  = bready_o && b_c >= b_d;
        arready_i = arvalid_o && ar_c >= ar_d;
        rvalid_i  = rready_o && r_c >= r_d;
        bresp_i = s_resp; rresp_i = s_resp; rdata_i = s_rdat;
        if (awvalid_o) begin aw_c++; aw_hi++; end
        if (wvalid_o) begin w_c++; w_hi++; end
        if (arvalid_o) begin ar_c++; ar_hi++; end
        if (bready_o) b_c++;
        if (rready_o) r_c++;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        slave_step();
    endtask

    task automatic start(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st);
        mem_req_i = 1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wd; mem_strb_i = st;
        cyc = 0; done_n = 0; prev_done = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; aw_hi = 0; w_hi = 0; ar_hi = 0;
        for (int k = 0; k < 4; k++) done_at[k] = -1;
        slave_step();
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        logic [31:0] c_aw, c_ar, c_wd;
        logic [3:0]  c_st;
        v = vt[i];
        @(negedge clk);
        aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d; ar_d = v.ar_d; r_d = v.r_d;
        s_resp = v.resp; s_rdat = v.rdat;
        start(v.we, v.addr, v.wdata, v.strb);
        c_aw = 0; c_ar = 0; c_wd = 0; c_st = 0;
        for (int k = 1; k <= v.done_exp + 2; k++) begin
            tick();
            if (cyc == v.drop) mem_req_i = 0;
            if (cyc == 1) begin c_aw = awaddr_o; c_ar = araddr_o; c_wd = wdata_o; c_st = wstrb_o; end
        end
        chk($sformatf("v%0d_done_count", i), done_n, 1);
        chk($sformatf("v%0d_done_cycle", i), done_at[0], v.done_exp);
        chk($sformatf("v%0d_rdata", i), mem_rdata_o, v.exp_rdata);
        chk($sformatf("v%0d_err", i), {31'b0, mem_err_o}, {31'b0, v.exp_err});
        if (v.we) begin
            chk($sformatf("v%0d_awaddr", i), c_aw, v.addr);
            chk($sformatf("v%0d_wdata", i), c_wd, v.wdata);
            chk($sformatf("v%0d_wstrb", i), {28'b0, c_st}, {28'b0, v.strb});
            chk($sformatf("v%0d_aw_cycles", i), aw_hi, v.aw_d + 1);
            chk($sformatf("v%0d_w_cycles", i), w_hi, v.w_d + 1);
            chk($sformatf("v%0d_no_ar", i), ar_hi, 0);
        end else begin
            chk($sformatf("v%0d_araddr", i), c_ar, v.addr);
            chk($sformatf("v%0d_ar_cycles", i), ar_hi, v.ar_d + 1);
            chk($sformatf("v%0d_no_aw", i), aw_hi, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            we    addr          wdata         strb     aw w  b  ar r  resp   rdat          drop done exp_rdata    err
        vt[0] = '{1'b0, 32'h0000_1000, 32'h0,        4'b0000, 0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 1, 3, 32'hDEADBEEF, 1'b0};
        vt[1] = '{1'b1, 32'h0000_2004, 32'h12345678, 4'b0011, 2, 0, 0, 0, 0, 2'b00, 32'hFFFFFFFF, 1, 5, 32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b0, 32'h0000_3000, 32'h0,        4'b0000, 0, 0, 0, 0, 0, 2'b10, 32'hA5A50001, 1, 3, 32'hA5A50001, 1'b1};
        vt[3] = '{1'b1, 32'h0000_4000, 32'hCAFEF00D, 4'b1111, 0, 3, 0, 0, 0, 2'b00, 32'h0,        1, 6, 32'hA5A50001, 1'b0};
        vt[4] = '{1'b0, 32'h0000_FFFC, 32'h0,        4'b0000, 0, 0, 0, 1, 2, 2'b11, 32'h0BADF00D, 3, 6, 32'h0BADF00D, 1'b1};
        vt[5] = '{1'b1, 32'h0000_0008, 32'h0F0F0F0F, 4'b1000, 1, 1, 1, 0, 0, 2'b10, 32'h0,        1, 5, 32'h0BADF00D, 1'b1};
        vt[6] = '{1'b1, 32'h0000_000C, 32'h00000001, 4'b0101, 0, 0, 0, 0, 0, 2'b01, 32'h0,        1, 3, 32'h0BADF00D, 1'b0};
        vt[7] = '{1'b0, 32'h0000_7000, 32'h0,        4'b0000, 0, 0, 0, 0, 0, 2'b00, 32'h13579BDF, 1, 3, 32'h13579BDF, 1'b0};
        s_resp = 0; s_rdat = 0; aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;

        @(negedge clk); @(negedge clk);
        chk("rst_ctrl", {25'b0, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, mem_done_o, mem_err_o}, 32'd0);
        chk("rst_rdata", mem_rdata_o, 32'h0);
        chk("rst_awaddr", awaddr_o, 32'h0);
        chk("rst_araddr", araddr_o, 32'h0);
        chk("rst_wdata", wdata_o, 32'h0);
        chk("rst_wstrb", {28'b0, wstrb_o}, 32'h0);
        chk("awprot", {29'b0, awprot_o}, {29'b0, PROT});
        chk("arprot", {29'b0, arprot_o}, {29'b0, PROT});
        rst = 0;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Request held high across a read then a write: two done pulses, no duplicate issue.
        @(negedge clk);
        aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0; s_resp = 2'b00; s_rdat = 32'h11112222;
        start(1'b0, 32'h0000_5000, 32'h0, 4'h0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (mem_done_o && done_n == 1) begin
                mem_we_i = 1; mem_addr_i = 32'h0000_6000; mem_wdata_i = 32'h55AA55AA; mem_strb_i = 4'hF;
            end else if (mem_done_o && done_n == 2) mem_req_i = 0;
        end
        chk("hold_done_count", done_n, 2);
        chk("hold_done0", done_at[0], 3);
        chk("hold_done1", done_at[1], 7);
        chk("hold_ar_cycles", ar_hi, 1);
        chk("hold_aw_cycles", aw_hi, 1);
        chk("hold_rdata", mem_rdata_o, 32'h11112222);
        chk("hold_awaddr", awaddr_o, 32'h0000_6000);

        // Asynchronous reset while waiting for the write response.
        @(negedge clk);
        b_d = 10; s_resp = 2'b00;
        start(1'b1, 32'h0000_9000, 32'hAAAA5555, 4'hF);
        tick();
        mem_req_i = 0;
        tick();
        chk("wrb_bready", {31'b0, bready_o}, 32'd1);
        #2 rst = 1;
        #1;
        chk("arst_ctrl", {26'b0, awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, mem_done_o}, 32'd0);
        chk("arst_rdata", mem_rdata_o, 32'h0);
        chk("arst_wstrb", {28'b0, wstrb_o}, 32'h0);
        tick();
        rst = 0;
        for (int k = 0; k < 5; k++) tick();
        chk("arst_no_done", done_n, 0);
        b_d = 0;
        run_vec(7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
